// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment scan controller.
// Segment encodings are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_OFF   = 8'hFF;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Values 10..15 have no glyph on this display and are shown dark.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_HEX_0;
      4'd1:    seg = SEG_HEX_1;
      4'd2:    seg = SEG_HEX_2;
      4'd3:    seg = SEG_HEX_3;
      4'd4:    seg = SEG_HEX_4;
      4'd5:    seg = SEG_HEX_5;
      4'd6:    seg = SEG_HEX_6;
      4'd7:    seg = SEG_HEX_7;
      4'd8:    seg = SEG_HEX_8;
      4'd9:    seg = SEG_HEX_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder shared by every digit position.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup through the package decode table.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Each digit slot is a blanking interval followed by the lit interval; inputs are snapshotted per frame.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_en,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_data,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{1'b1}};
  localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);

  scan_state_t          state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic [4*DIGITS-1:0]  snap_data_r;
  logic [DIGITS-1:0]    snap_en_r;
  logic [DIGITS-1:0]    snap_dp_r;

  logic [3:0]           nibble_s;
  logic [6:0]           dec_s;
  logic [DIGITS-1:0]    lit_sel_s;
  logic [7:0]           lit_data_s;

  seg7_hex_decoder u_dec (
    .nibble (nibble_s),
    .seg    (dec_s)
  );

  // Select the current digit's snapshot and form the pattern it should show when lit.
  always_comb begin
    nibble_s = snap_data_r[{idx_r, 2'b00} +: 4];
    if (snap_en_r[idx_r]) begin
      lit_sel_s  = ~(SEL_ONE << idx_r);
      lit_data_s = {~snap_dp_r[idx_r], dec_s};
    end else begin
      lit_sel_s  = SEL_OFF;
      lit_data_s = SEG_OFF;
    end
  end

  // Scan sequencer: slot counter, digit index, frame snapshot and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      snap_data_r <= '0;
      snap_en_r   <= '0;
      snap_dp_r   <= '0;
      seg_sel     <= SEL_OFF;
      seg_data    <= SEG_OFF;
      frame_tick  <= 1'b0;
    end else if (!scan_en) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      seg_sel    <= SEL_OFF;
      seg_data   <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= BLANK;
          cnt_r       <= '0;
          idx_r       <= '0;
          snap_data_r <= digit_data;
          snap_en_r   <= digit_en;
          snap_dp_r   <= dp;
          seg_sel     <= SEL_OFF;
          seg_data    <= SEG_OFF;
          frame_tick  <= 1'b1;
        end
        BLANK: begin
          // The counter runs across the whole slot so SHOW ends on the slot boundary.
          frame_tick <= 1'b0;
          cnt_r      <= cnt_r + CNT_ONE;
          if (cnt_r == BLANK_LAST) begin
            state_r  <= SHOW;
            seg_sel  <= lit_sel_s;
            seg_data <= lit_data_s;
          end else begin
            seg_sel  <= SEL_OFF;
            seg_data <= SEG_OFF;
          end
        end
        SHOW: begin
          if (cnt_r == SLOT_LAST) begin
            // Deselect on the same edge the slot ends; the next digit waits out its blanking.
            state_r  <= BLANK;
            cnt_r    <= '0;
            seg_sel  <= SEL_OFF;
            seg_data <= SEG_OFF;
            if (idx_r == IDX_LAST) begin
              idx_r       <= '0;
              snap_data_r <= digit_data;
              snap_en_r   <= digit_en;
              snap_dp_r   <= dp;
              frame_tick  <= 1'b1;
            end else begin
              idx_r      <= idx_r + IDX_ONE;
              frame_tick <= 1'b0;
            end
          end else begin
            cnt_r      <= cnt_r + CNT_ONE;
            seg_sel    <= lit_sel_s;
            seg_data   <= lit_data_s;
            frame_tick <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= '0;
          idx_r      <= '0;
          seg_sel    <= SEL_OFF;
          seg_data   <= SEG_OFF;
          frame_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule
